onehot_scan_decoder: RTL and testbench
======================================

Name: onehot_scan_decoder

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable, used as the select/anode driver for multiplexed outputs such as display digits and LED banks.
- Two operating styles:
  - Direct decode of an external select.
  - Autonomous scan that walks the one-hot output up or down at a prescaled rate over a programmable range 0..last.
- Also reports the current index and flags wrap-around.

Parameters:
- SEL_W, 3, select/index width; OUT_W = 2**SEL_W is a derived localparam, not overridable.
- DIV_W, 16, prescaler divisor width.
- ACTIVE_LOW_OUT, 0, 1 inverts every dout bit (active-low anodes); idle = all ones.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; 0 blanks dout and freezes all state.
- mode  in  2  00 OFF, 01 DECODE, 10 SCAN_UP, 11 SCAN_DN.
- sel  in  SEL_W  decode select (DECODE) / load value (SCAN).
- load  in  1  SCAN modes: idx <= sel, prescaler cleared.
- div  in  DIV_W  scan step every div+1 clocks.
- last  in  SEL_W  highest scan index (range 0..last).
- dout  out  OUT_W  one-hot output, polarity per ACTIVE_LOW_OUT.
- idx  out  SEL_W  current index register.
- active  out  1  dout currently driving a one-hot value.
- wrap  out  1  single-cycle pulse on scan wrap-around.

Behaviour:
- Reset (async, rst_n=0):
  - Cleared immediately, independent of clk: idx=0, active=0, wrap=0, prescaler cnt=0, mode_q=OFF.
  - dout = all inactive (0, or all ones if ACTIVE_LOW_OUT).
  - Release is synchronous to clk; first update on the first rising edge after release.
- Register state:
  - mode_q: registered copy of mode; acts as the state machine, states OFF, DECODE, SCAN_UP, SCAN_DN.
  - Transition = mode sampled each clock while en=1.
  - A mode change clears cnt and wrap in that same cycle.
- Output:
  - dout = active ? (1 << idx) : 0, then XOR all-ones if ACTIVE_LOW_OUT.
  - Decoded combinationally from registers only; no input-to-output combinational path.
- en=0:
  - active<=0; idx, cnt and mode_q hold; wrap<=0.
  - Re-enabling resumes from the held idx and cnt.
- OFF: active<=0, idx holds, cnt<=0.
- DECODE:
  - idx<=sel, active<=1 every cycle; latency sel->dout = 1 clock.
  - load, div and last ignored.
- SCAN_UP / SCAN_DN, priority order:
  1. load: idx<=sel, cnt<=0, wrap<=0. sel > last is allowed; it is resolved on the next tick.
  2. tick: tick = (cnt == div). On tick, cnt<=0; otherwise cnt<=cnt+1.
- Scan step on tick:
  - UP: if idx >= last then idx<=0, wrap<=1; else idx<=idx+1.
  - DN: if idx == 0 or idx > last then idx<=last, wrap<=1; else idx<=idx-1.
  - active<=1 throughout the scan modes.
- Scan rate and range:
  - div=0: step every clock.
  - Step period = div+1 clocks; maximum = 2^DIV_W clocks.
  - last=0: idx stays 0 and wrap pulses on every tick.
- wrap: high for exactly one clock, the cycle after the wrapping edge; otherwise 0.
- last changed mid-scan: takes effect at the next tick evaluation, per the rules above.
- Arithmetic: all index arithmetic is modulo 2^SEL_W; the wrap rules guarantee idx never leaves 0..OUT_W-1. cnt is DIV_W bits unsigned.

Decomposition:
- Shared package (decoder_pkg) holds:
  - the mode typedef (enum, 2 bits: MODE_OFF, MODE_DECODE, MODE_SCAN_UP, MODE_SCAN_DN);
  - a function onehot(idx) returning OUT_W bits.
- One natural sub-module, scan_prescaler:
  - ports: clk, rst_n, clr, hold, div → tick;
  - owns cnt.
- Everything else stays in onehot_scan_decoder.

Test Plan:
- Reset/decode (SEL_W=3): rst_n=0 mid-run → dout=8'h00, idx=0 asynchronously. Then en=1, mode=DECODE, sel=5 → next clock dout=8'b0010_0000, active=1.
- Scan up (div=2, last=7, load sel=0): dout steps 01→02→04…→80 every 3 clocks. After 80, the next step gives 01 with wrap=1 for exactly one cycle.
- Scan down with reduced range (last=3, load sel=1): idx sequence 1,0,3,2,1,0,3. wrap pulses on each 0→3 transition.
- Out-of-range and last=0:
  - SCAN_UP, idx=6, last changed to 2: next tick idx=0 with wrap=1.
  - last=0, div=0: dout stays 01 and wrap is high every clock.
- Enable freeze and polarity (ACTIVE_LOW_OUT=1, SCAN_UP at idx=4):
  - en=0 for 10 clocks → dout=8'hFF and idx stays 4.
  - en=1 → dout=8'hEF, and scan resumes with the prescaler count preserved.
- Priority and mode change:
  - load asserted on a tick cycle → idx=sel, no step, no wrap.
  - Switching SCAN→DECODE → cnt cleared and dout follows sel the next clock.

Source files
------------

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the one-hot scan decoder slice.
//   mode_e   : 2-bit operating mode (OFF, DECODE, SCAN_UP, SCAN_DN)
//   onehot() : index -> one-hot vector. It is sized for the widest supported
//              select (MAX_SEL_W), so callers truncate the result to their own
//              OUT_W with a cast.
// -----------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_DECODE  = 2'b01,
    MODE_SCAN_UP = 2'b10,
    MODE_SCAN_DN = 2'b11
  } mode_e;

  // Widest select the helper supports. SEL_W of any instance must not exceed it.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel_val);
    logic [MAX_OUT_W-1:0] vec;
    vec          = '0;
    vec[sel_val] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running divide-by-(div+1) counter that paces the scan.
//   clk   in  : system clock, rising edge
//   rst_n in  : asynchronous active-low reset, clears cnt
//   clr   in  : synchronous clear of cnt. Takes priority over hold.
//   hold  in  : freeze cnt (global enable low)
//   div   in  : terminal count. tick asserts while cnt == div.
//   tick  out : combinational, high while the count sits at div
// -----------------------------------------------------------------------------
module scan_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;

  assign tick = (cnt_reg == div);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (!hold) begin
      // If div is lowered below the current count, the count simply runs on
      // and wraps modulo 2^DIV_W before it matches again.
      cnt_next = tick ? '0 : cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// -----------------------------------------------------------------------------
// onehot_scan_decoder
// Registered SEL_W -> 2^SEL_W one-hot select driver. It has two uses:
// direct decode of an external select, and an autonomous up/down scan over
// the range 0..last at a prescaled rate.
//   clk    in  : system clock, rising edge
//   rst_n  in  : asynchronous active-low reset
//   en     in  : global enable. 0 blanks dout and freezes idx/cnt/mode.
//   mode   in  : 00 OFF, 01 DECODE, 10 SCAN_UP, 11 SCAN_DN
//   sel    in  : decode select (DECODE) or load value (SCAN)
//   load   in  : in the SCAN modes, idx <= sel and the prescaler is cleared
//   div    in  : the scan steps every div+1 clocks
//   last   in  : highest scan index
//   dout   out : one-hot output. Every bit is inverted when ACTIVE_LOW_OUT=1.
//   idx    out : current index register
//   active out : dout is driving a one-hot value
//   wrap   out : one-cycle pulse after a scan wrap-around
// -----------------------------------------------------------------------------
module onehot_scan_decoder
  import decoder_pkg::*;
#(
  parameter int  SEL_W          = 3,
  parameter int  DIV_W          = 16,
  parameter bit  ACTIVE_LOW_OUT = 1'b0,
  localparam int OUT_W          = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic [SEL_W-1:0] last,
  output logic [OUT_W-1:0] dout,
  output logic [SEL_W-1:0] idx,
  output logic             active,
  output logic             wrap
);

  mode_e            mode_in;
  mode_e            mode_reg;
  mode_e            mode_next;
  logic [SEL_W-1:0] idx_reg;
  logic [SEL_W-1:0] idx_next;
  logic             active_reg;
  logic             active_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             mode_change;
  logic             scan_mode;
  logic             tick;
  logic             pre_clr;
  logic [OUT_W-1:0] dec_vec;

  assign mode_in     = mode_e'(mode);
  assign mode_change = (mode_in != mode_reg);
  assign scan_mode   = (mode_in == MODE_SCAN_UP) || (mode_in == MODE_SCAN_DN);

  // The count only runs in a steady scan. Entering a mode, loading, or
  // sitting in OFF/DECODE all restart the step period from zero.
  assign pre_clr = en && (mode_change || !scan_mode || load);

  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .hold  (!en),
    .div   (div),
    .tick  (tick)
  );

  always_comb begin
    idx_next    = idx_reg;
    active_next = active_reg;
    mode_next   = mode_reg;
    wrap_next   = 1'b0;
    if (!en) begin
      active_next = 1'b0;
    end else begin
      // The incoming mode acts in the same cycle it is sampled. mode_reg is
      // only used to detect a change.
      mode_next = mode_in;
      case (mode_in)
        MODE_OFF: begin
          active_next = 1'b0;
        end
        MODE_DECODE: begin
          idx_next    = sel;
          active_next = 1'b1;
        end
        MODE_SCAN_UP: begin
          active_next = 1'b1;
          if (load) begin
            idx_next = sel;
          end else if (!mode_change && tick) begin
            // ">=" also pulls an out-of-range idx (above last) back to 0.
            if (idx_reg >= last) begin
              idx_next  = '0;
              wrap_next = 1'b1;
            end else begin
              idx_next = idx_reg + SEL_W'(1);
            end
          end
        end
        MODE_SCAN_DN: begin
          active_next = 1'b1;
          if (load) begin
            idx_next = sel;
          end else if (!mode_change && tick) begin
            if ((idx_reg == '0) || (idx_reg > last)) begin
              idx_next  = last;
              wrap_next = 1'b1;
            end else begin
              idx_next = idx_reg - SEL_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg   <= MODE_OFF;
      idx_reg    <= '0;
      active_reg <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      mode_reg   <= mode_next;
      idx_reg    <= idx_next;
      active_reg <= active_next;
      wrap_reg   <= wrap_next;
    end
  end

  // dout comes from registers only, so there is no input-to-output path.
  assign dec_vec = active_reg ? OUT_W'(onehot(MAX_SEL_W'(idx_reg))) : '0;

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pol
    assign dout[gi] = dec_vec[gi] ^ ACTIVE_LOW_OUT;
  end

  assign idx    = idx_reg;
  assign active = active_reg;
  assign wrap   = wrap_reg;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_onehot_scan_decoder
// Bench for two decoder instances that share one stimulus: one with
// active-high outputs and one with active-low outputs. A behavioural
// cycle model is compared against both on every falling edge. Directed
// phases add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_onehot_scan_decoder;

  localparam int SEL_W = 3;
  localparam int DIV_W = 16;
  localparam int OUT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic             load;
  logic [DIV_W-1:0] div;
  logic [SEL_W-1:0] last;

  logic [OUT_W-1:0] dout_h, dout_l;
  logic [SEL_W-1:0] idx_h, idx_l;
  logic             active_h, active_l, wrap_h, wrap_l;

  int total_cnt = 0;
  int pass_cnt  = 0;

  onehot_scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACTIVE_LOW_OUT(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .div(div), .last(last), .dout(dout_h), .idx(idx_h), .active(active_h), .wrap(wrap_h)
  );

  onehot_scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACTIVE_LOW_OUT(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .div(div), .last(last), .dout(dout_l), .idx(idx_l), .active(active_l), .wrap(wrap_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int idx;
    int cnt;
    int act;
    int wrap;
    int mode;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(mstate_t s, int en_i, int mode_i, int sel_i,
                                         int load_i, int div_i, int last_i);
    mstate_t n;
    n      = s;
    n.wrap = 0;
    if (en_i == 0) begin
      n.act = 0;
      return n;
    end
    n.mode = mode_i;
    if (mode_i == 0) begin
      n.act = 0;
      n.cnt = 0;
    end else if (mode_i == 1) begin
      n.idx = sel_i;
      n.act = 1;
      n.cnt = 0;
    end else begin
      n.act = 1;
      if (load_i != 0) begin
        n.idx = sel_i;
        n.cnt = 0;
      end else if (mode_i != s.mode) begin
        n.cnt = 0;
      end else if (s.cnt == div_i) begin
        n.cnt = 0;
        if (mode_i == 2) begin
          if (s.idx >= last_i) begin n.idx = 0; n.wrap = 1; end
          else n.idx = s.idx + 1;
        end else begin
          if (s.idx == 0 || s.idx > last_i) begin n.idx = last_i; n.wrap = 1; end
          else n.idx = s.idx - 1;
        end
      end else begin
        n.cnt = (s.cnt + 1) % (1 << DIV_W);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_step(m, int'(en), int'(mode), int'(sel), int'(load), int'(div), int'(last));
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int exp_h;
    exp_h = (m.act != 0) ? (1 << m.idx) : 0;
    check("dout_h", int'(dout_h), exp_h);
    check("dout_l", int'(dout_l), exp_h ^ 255);
    check("idx_h", int'(idx_h), m.idx);
    check("idx_l", int'(idx_l), m.idx);
    check("active", int'(active_h), m.act);
    check("wrap", int'(wrap_h), m.wrap);
    check("wrap_l", int'(wrap_l), m.wrap);
  end

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int exp_idx_dn[6];
    int exp_wrap_dn[6];
    exp_idx_dn  = '{0, 3, 2, 1, 0, 3};
    exp_wrap_dn = '{0, 1, 0, 0, 0, 1};

    rst_n = 1'b0; en = 1'b0; mode = 2'b00; sel = '0; load = 1'b0; div = '0; last = 3'd7;
    clk_step();
    clk_step();
    check("rst_dout_h", int'(dout_h), 'h00);
    check("rst_dout_l", int'(dout_l), 'hFF);
    check("rst_idx", int'(idx_h), 0);
    check("rst_active", int'(active_h), 0);
    check("rst_wrap", int'(wrap_h), 0);
    rst_n = 1'b1;

    // Decode, then an asynchronous reset in mid-cycle.
    en = 1'b1; mode = 2'b01; sel = 3'd2;
    clk_step();
    check("dec_sel2", int'(dout_h), 'h04);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", int'(dout_h), 'h00);
    check("async_rst_idx", int'(idx_h), 0);
    check("async_rst_dout_l", int'(dout_l), 'hFF);
    @(posedge clk); #1 rst_n = 1'b1;
    sel = 3'd5;
    clk_step();
    check("dec_sel5", int'(dout_h), 'h20);
    check("dec_active", int'(active_h), 1);
    $display("phase decode: sel=5 dout=%02h", dout_h);

    // Scan up over the full range, with div=2.
    mode = 2'b10; load = 1'b1; sel = 3'd0; div = 16'd2; last = 3'd7;
    clk_step();
    load = 1'b0;
    check("up_load", int'(dout_h), 'h01);
    for (int k = 1; k < 8; k++) begin
      int one;
      one = 1;
      clk_step();
      clk_step();
      check("up_hold", int'(dout_h), one << (k - 1));
      clk_step();
      check("up_step", int'(dout_h), one << k);
      check("up_nowrap", int'(wrap_h), 0);
    end
    clk_step();
    clk_step();
    clk_step();
    check("up_wrap_dout", int'(dout_h), 'h01);
    check("up_wrap_pulse", int'(wrap_h), 1);
    clk_step();
    check("up_wrap_clear", int'(wrap_h), 0);
    $display("phase scan_up: wrapped to dout=%02h", dout_h);

    // Scan down over the reduced range 0..3.
    mode = 2'b11; load = 1'b1; sel = 3'd1; last = 3'd3; div = 16'd0;
    clk_step();
    load = 1'b0;
    check("dn_load", int'(idx_h), 1);
    for (int k = 0; k < 6; k++) begin
      clk_step();
      check("dn_idx", int'(idx_h), exp_idx_dn[k]);
      check("dn_wrap", int'(wrap_h), exp_wrap_dn[k]);
    end
    $display("phase scan_dn: idx=%0d", idx_h);

    // An out-of-range idx is resolved on the next tick, then last=0.
    mode = 2'b10; load = 1'b1; sel = 3'd6; last = 3'd7; div = 16'd1;
    clk_step();
    load = 1'b0; last = 3'd2;
    clk_step();
    check("oor_wait", int'(idx_h), 6);
    clk_step();
    check("oor_idx", int'(idx_h), 0);
    check("oor_wrap", int'(wrap_h), 1);
    last = 3'd0; div = 16'd0;
    for (int k = 0; k < 5; k++) begin
      clk_step();
      check("last0_dout", int'(dout_h), 'h01);
      check("last0_wrap", int'(wrap_h), 1);
    end
    $display("phase range: last=0 dout=%02h", dout_h);

    // Freeze with en=0. The prescaler count must survive.
    last = 3'd7; div = 16'd3; load = 1'b1; sel = 3'd4;
    clk_step();
    load = 1'b0;
    clk_step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clk_step();
      check("frz_dout_l", int'(dout_l), 'hFF);
      check("frz_idx", int'(idx_h), 4);
    end
    en = 1'b1;
    clk_step();
    check("resume_dout_l", int'(dout_l), 'hEF);
    clk_step();
    check("resume_hold", int'(idx_h), 4);
    clk_step();
    check("resume_step", int'(idx_h), 5);
    check("resume_dout_l2", int'(dout_l), 'hDF);
    $display("phase freeze: idx=%0d dout_l=%02h", idx_h, dout_l);

    // A load on a tick cycle wins. Then a mode change.
    div = 16'd1;
    clk_step();
    load = 1'b1; sel = 3'd2;
    clk_step();
    load = 1'b0;
    check("prio_idx", int'(idx_h), 2);
    check("prio_wrap", int'(wrap_h), 0);
    clk_step();
    mode = 2'b01; sel = 3'd3;
    clk_step();
    check("to_dec_dout", int'(dout_h), 'h08);
    mode = 2'b00;
    clk_step();
    check("off_dout", int'(dout_h), 'h00);
    check("off_idx", int'(idx_h), 3);
    mode = 2'b10; div = 16'd0;
    clk_step();
    check("reenter_idx", int'(idx_h), 3);
    clk_step();
    check("reenter_step", int'(idx_h), 4);
    $display("phase priority: idx=%0d", idx_h);

    clk_step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
